// File: rtl/spi_frame_scheduler.sv
// spi_frame_scheduler: round-robin arbiter that frames 3-byte transfers
// (header, LSB, MSB) from two 16-bit requesters onto one SPI byte master.
module spi_frame_scheduler #(
    parameter logic [7:0] HDR0       = 8'hA0,
    parameter logic [7:0] HDR1       = 8'hB0,
    parameter int         GAP_CYCLES = 4,
    parameter int         TIMEOUT    = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [15:0] data0,
    output logic        ack0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic        ack1,
    input  logic        m_ready,
    input  logic        m_done,
    output logic        m_start,
    output logic [7:0]  m_tx_data,
    output logic        cs_n,
    output logic        busy,
    output logic        grant_id,
    output logic        err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, CS_SETUP, SEND, WAIT_DONE, GAP} state_t;

    state_t        state_q;
    logic [23:0]   frame_q;
    logic [1:0]    idx_q;
    logic [TW-1:0] timer_q;
    logic [GW-1:0] gap_q;
    logic          last_q;
    logic          ack0_q, ack1_q, m_start_q, cs_n_q, busy_q, grant_q, err_q;
    logic [7:0]    tx_q;
    logic          win;
    logic [7:0]    cur_byte;

    // On contention the requester that did not win last time gets the bus.
    assign win      = (req0 && req1) ? ~last_q : req1;
    assign cur_byte = (idx_q == 2'd0) ? frame_q[7:0] :
                      (idx_q == 2'd1) ? frame_q[15:8] : frame_q[23:16];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            idx_q     <= '0;
            timer_q   <= '0;
            gap_q     <= '0;
            last_q    <= 1'b1;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            m_start_q <= 1'b0;
            tx_q      <= '0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            grant_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            m_start_q <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                IDLE: if (req0 || req1) begin
                    state_q <= CS_SETUP;
                    cs_n_q  <= 1'b0;
                    busy_q  <= 1'b1;
                    grant_q <= win;
                    last_q  <= win;
                    frame_q <= win ? {data1, HDR1} : {data0, HDR0};
                    idx_q   <= '0;
                end
                CS_SETUP: state_q <= SEND;
                SEND: if (m_ready) begin
                    m_start_q <= 1'b1;
                    tx_q      <= cur_byte;
                    timer_q   <= '0;
                    state_q   <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (m_done) begin
                        if (idx_q == 2'd2) begin
                            ack0_q  <= ~grant_q;
                            ack1_q  <= grant_q;
                            cs_n_q  <= 1'b1;
                            gap_q   <= '0;
                            state_q <= GAP;
                        end else begin
                            idx_q   <= idx_q + 2'd1;
                            state_q <= SEND;
                        end
                    end else if (timer_q == TW'(TIMEOUT)) begin
                        err_q   <= 1'b1;
                        cs_n_q  <= 1'b1;
                        gap_q   <= '0;
                        state_q <= GAP;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                GAP: if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end else begin
                    gap_q <= gap_q + GW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign m_start   = m_start_q;
    assign m_tx_data = tx_q;
    assign cs_n      = cs_n_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;
    assign err       = err_q;
endmodule

// File: tb/tb_spi_frame_scheduler.sv
// tb_spi_frame_scheduler: directed checks of arbitration, framing, stall,
// timeout, latched payload and mid-frame reset.
module tb_spi_frame_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] data0 = '0, data1 = '0;
    logic        m_ready = 1'b0, m_done = 1'b0;
    logic        ack0, ack1, m_start, cs_n, busy, grant_id, err;
    logic [7:0]  m_tx_data;
    int          checks = 0, failures = 0, cyc = 0, c0, n;

    spi_frame_scheduler dut (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .m_ready(m_ready), .m_done(m_done),
        .m_start(m_start), .m_tx_data(m_tx_data),
        .cs_n(cs_n), .busy(busy), .grant_id(grant_id), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_start(input string tag);
        int k = 0;
        while (!m_start && k < 200) begin
            tick();
            k++;
        end
        chk({tag, "_start"}, m_start, 1);
    endtask

    // Master model: answers m_done d cycles after m_start, checks byte and stability.
    task automatic do_byte(input string tag, input logic [7:0] exp, input int d);
        wait_start(tag);
        chk({tag, "_tx"}, m_tx_data, exp);
        repeat (d) tick();
        chk({tag, "_stable"}, m_tx_data, exp);
        chk({tag, "_cs"}, cs_n, 0);
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
    endtask

    initial begin
        tick();
        chk("rst_cs", cs_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_start", m_start, 0);
        chk("rst_tx", m_tx_data, 0);
        chk("rst_ack", {ack0, ack1, err, grant_id}, 0);
        reset = 1'b0;
        tick();
        // 1: single frame, D=8
        req0 = 1'b1; data0 = 16'h1234; m_ready = 1'b1; c0 = cyc;
        tick();
        chk("t1_cs_fall", cs_n, 0);
        chk("t1_busy", busy, 1);
        chk("t1_grant", grant_id, 0);
        tick();
        chk("t1_pre_start", {cs_n, m_start}, 0);
        do_byte("t1b0", 8'hA0, 8);
        do_byte("t1b1", 8'h34, 8);
        do_byte("t1b2", 8'h12, 8);
        chk("t1_ack", ack0, 1);
        chk("t1_cs_rise", cs_n, 1);
        chk("t1_latency", cyc - c0, 32);
        req0 = 1'b0;
        tick();
        chk("t1_ack_once", ack0, 0);
        tick(); tick();
        chk("t1_busy_gap", busy, 1);
        tick();
        chk("t1_busy_low", busy, 0);
        // 2: contention after reset
        reset = 1'b1; tick(); reset = 1'b0; tick();
        req0 = 1'b1; req1 = 1'b1; data0 = 16'h5678; data1 = 16'hBEEF;
        tick();
        chk("t2_grant0", grant_id, 0);
        do_byte("t2a0", 8'hA0, 2);
        do_byte("t2a1", 8'h78, 2);
        do_byte("t2a2", 8'h56, 2);
        chk("t2_acks_a", {ack0, ack1}, 2'b10);
        req0 = 1'b0;
        do_byte("t2b0", 8'hB0, 2);
        chk("t2_grant1", grant_id, 1);
        do_byte("t2b1", 8'hEF, 2);
        do_byte("t2b2", 8'hBE, 2);
        chk("t2_acks_b", {ack0, ack1}, 2'b01);
        req0 = 1'b1;
        tick();
        chk("t2_ack1_once", ack1, 0);
        do_byte("t2c0", 8'hA0, 2);
        chk("t2_grant0_again", grant_id, 0);
        do_byte("t2c1", 8'h78, 2);
        do_byte("t2c2", 8'h56, 2);
        chk("t2_acks_c", {ack0, ack1}, 2'b10);
        req0 = 1'b0;
        do_byte("t2d0", 8'hB0, 2);
        do_byte("t2d1", 8'hEF, 2);
        do_byte("t2d2", 8'hBE, 2);
        chk("t2_acks_d", {ack0, ack1}, 2'b01);
        req1 = 1'b0;
        repeat (4) tick();
        // 3: m_ready stalled low 20 cycles
        m_ready = 1'b0; req0 = 1'b1; data0 = 16'h1234;
        n = 0;
        repeat (20) begin
            tick();
            if (m_start || cs_n) n++;
        end
        chk("t3_stall_quiet", n, 0);
        m_ready = 1'b1;
        tick();
        chk("t3_start_after_ready", m_start, 1);
        do_byte("t3b0", 8'hA0, 5);
        do_byte("t3b1", 8'h34, 5);
        do_byte("t3b2", 8'h12, 5);
        chk("t3_ack", ack0, 1);
        req0 = 1'b0;
        repeat (4) tick();
        // 4: timeout on the second byte, then full retry
        req0 = 1'b1;
        do_byte("t4b0", 8'hA0, 2);
        wait_start("t4b1");
        chk("t4b1_tx", m_tx_data, 8'h34);
        repeat (1023) tick();
        chk("t4_no_err_yet", {err, cs_n}, 0);
        tick();
        chk("t4_err", err, 1);
        chk("t4_cs", cs_n, 1);
        chk("t4_no_ack", ack0, 0);
        tick();
        chk("t4_err_once", err, 0);
        do_byte("t4r0", 8'hA0, 2);
        do_byte("t4r1", 8'h34, 2);
        do_byte("t4r2", 8'h12, 2);
        chk("t4_retry_ack", ack0, 1);
        req0 = 1'b0;
        repeat (4) tick();
        // 5: payload change and req drop after grant
        req0 = 1'b1; data0 = 16'h1234;
        tick();
        data0 = 16'hFFFF;
        do_byte("t5b0", 8'hA0, 3);
        req0 = 1'b0;
        do_byte("t5b1", 8'h34, 3);
        do_byte("t5b2", 8'h12, 3);
        chk("t5_ack", ack0, 1);
        repeat (4) tick();
        // 6: reset during the last byte's WAIT_DONE
        req1 = 1'b1; data1 = 16'hCAFE;
        do_byte("t6b0", 8'hB0, 2);
        do_byte("t6b1", 8'hFE, 2);
        wait_start("t6b2");
        tick(); tick();
        reset = 1'b1;
        #1;
        chk("t6_rst_cs", cs_n, 1);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_pulses", {ack0, ack1, err, m_start}, 0);
        tick();
        reset = 1'b0;
        tick();
        do_byte("t6r0", 8'hB0, 2);
        do_byte("t6r1", 8'hFE, 2);
        do_byte("t6r2", 8'hCA, 2);
        chk("t6_ack", ack1, 1);
        req1 = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_frame_scheduler.md
Name: spi_frame_scheduler

Overview:
Shares one byte-wide SPI master between two 16-bit requesters, e.g. the up-counter value stream and the LED command path. Arbitrates round-robin between them. Each grant is sequenced as one chip-select-framed transfer of 3 bytes: header, LSB, MSB. Sits between the requesters' control units and the SPI master. It owns cs_n and includes a done-timeout abort.

Parameters:
HDR0, 8'hA0, header byte sent for requester 0
HDR1, 8'hB0, header byte sent for requester 1
GAP_CYCLES, 4, idle cycles with cs_n high between frames (>=1)
TIMEOUT, 1023, max cycles in WAIT_DONE before abort (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req0  in  1  requester 0 frame request; held high until ack0
data0  in  16  requester 0 payload; sampled at grant
ack0  out  1  one-cycle pulse: requester 0 frame completed
req1  in  1  requester 1 frame request; held high until ack1
data1  in  16  requester 1 payload; sampled at grant
ack1  out  1  one-cycle pulse: requester 1 frame completed
m_ready  in  1  SPI master idle, can accept a byte
m_done  in  1  SPI master one-cycle pulse: byte finished
m_start  out  1  one-cycle pulse: launch byte m_tx_data
m_tx_data  out  8  byte to SPI master; stable from m_start until m_done
cs_n  out  1  slave select, active-low, low for whole frame
busy  out  1  high from grant until GAP ends
grant_id  out  1  requester owning current frame
err  out  1  one-cycle pulse: frame aborted by timeout

Behaviour:
- Reset is asynchronous, active-high. Reset values:
  - State IDLE.
  - cs_n=1, m_start=0, m_tx_data=0, ack0=ack1=0, err=0, busy=0, grant_id=0.
  - last_grant=1, byte index 0, timers 0.
- All outputs are registered.
- FSM states: IDLE, CS_SETUP, SEND, WAIT_DONE, GAP.
- IDLE:
  - Any req high at cycle T: pick the winner. If both are high, grant the requester != last_grant. Otherwise grant the one that is high.
  - At T+1: state CS_SETUP, cs_n=0, busy=1, grant_id=winner, last_grant=winner.
  - Latch the frame bytes: {HDRx, data[7:0], data[15:8]}. Byte index=0.
- CS_SETUP: exactly 1 cycle, then SEND. This guarantees one cycle of cs_n low before the first m_start.
- SEND:
  - Waits for m_ready.
  - In the cycle m_ready=1 is sampled, the next cycle shows m_start=1 for one cycle, m_tx_data=byte[index], and state WAIT_DONE with timer=0.
  - m_done in SEND is ignored.
- WAIT_DONE:
  - The timer increments each cycle.
  - m_done with index<2: index+1, back to SEND.
  - m_done with index==2: next cycle ackX=1 (one cycle), cs_n=1, state GAP.
  - If the timer reaches TIMEOUT before m_done: next cycle err=1, cs_n=1, no ack, state GAP. The requester keeps req and is re-arbitrated later.
  - If m_done and timeout occur in the same cycle, m_done wins.
- GAP:
  - cs_n=1, busy=1, requests are not sampled.
  - After GAP_CYCLES cycles, return to IDLE with busy=0. A request can be granted the following cycle.
- Request contract:
  - req changes and data changes while granted are ignored; the latched data is used.
  - If req drops mid-frame, the frame still completes and ack still pulses.
- Minimum frame latency with an always-ready master that returns m_done D cycles after m_start: 2 + 3*(2+D) cycles from req to ack.
- Reset mid-frame: cs_n returns high immediately (asynchronously), and all pulses clear.

Test Plan:
1. Single frame: req0=1, data0=16'h1234, m_ready=1, m_done 8 cycles after each m_start.
   -> cs_n falls 1 cycle before the first m_start.
   -> Bytes A0, 34, 12 in order.
   -> ack0 pulses once as cs_n rises.
   -> busy low GAP_CYCLES=4 cycles later.
2. Contention: req0 and req1 rise in the same cycle after reset.
   -> Requester 0 is granted first; then requester 1 with header B0.
   -> Reassert both: requester 0 again (alternating). Each ack pulses exactly once.
3. m_ready stalled low 20 cycles in SEND.
   -> No m_start and cs_n held low.
   -> m_start issues 1 cycle after m_ready rises; m_tx_data stays stable until m_done.
4. Timeout: m_done withheld after the second byte.
   -> err pulses at TIMEOUT+1 cycles after that m_start. cs_n=1, no ack.
   -> After the gap the same req is re-granted and the full frame restarts with the header.
5. Data change mid-frame: data0 changed to 16'hFFFF after grant.
   -> Transmitted bytes still reflect the latched 16'h1234.
6. Reset asserted during WAIT_DONE of byte 2.
   -> cs_n=1 and busy=0 immediately, no ack/err.
   -> After release, a new req starts a fresh frame from the header.
